// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared definitions for the riscv_mem_arbiter slice.
//   - FSM state encoding (IDLE/BUSY/RESP)
//   - default address/data widths
//   - owner encoding that records which requester holds the memory port
package riscv_mem_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle around the arbiter: fetch port (if_*), load/store port (lsu_*),
// external memory port (mem_*) and the busy status flag.
//   slave  : arbiter view (takes requests, drives acks and the mem_* request)
//   master : environment view (core + memory side), directions mirrored
interface riscv_mem_arbiter_if
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  localparam int BW = DW / 8;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_err;

  logic          lsu_req;
  logic          lsu_we;
  logic [BW-1:0] lsu_be;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_ack;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_err;

  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr,
    input  lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
    input  mem_ack, mem_rdata,
    output if_ack, if_rdata, if_err,
    output lsu_ack, lsu_rdata, lsu_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
    output mem_ack, mem_rdata,
    input  if_ack, if_rdata, if_err,
    input  lsu_ack, lsu_rdata, lsu_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/riscv_mem_arbiter_timeout.sv
// Access watchdog for the arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return the count to zero (has priority over en)
//   en         : count one more cycle spent waiting on memory
//   expired    : this is the last permitted waiting cycle (count == TIMEOUT_CYC-1)
module riscv_mem_arbiter_timeout #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_q;

  // The owner clears on the expiry cycle itself, so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (clr) begin
      tmo_q <= '0;
    end else if (en) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign expired = en && (tmo_q == TMO_LAST);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares the single external memory port between instruction fetch and the
// load/store unit. LSU has priority; after STARVE_LIMIT back-to-back LSU
// grants with a fetch waiting, the fetch is forced through. Each access is
// registered onto mem_*, completes on mem_ack or is aborted with err after
// TIMEOUT_CYC cycles, and is answered with a one-cycle ack to its owner.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : if_* fetch port, lsu_* load/store port, mem_* memory port, busy
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic clk,
  input  logic rst_n,
  riscv_mem_arbiter_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    state_q;
  logic          owner_q;
  logic [SW-1:0] streak_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [BW-1:0] be_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic grant_if;
  logic tmo_en;
  logic tmo_clr;
  logic tmo_expired;
  logic resp_if;
  logic resp_lsu;

  // Fetch wins only when alone or when the LSU streak has hit the limit.
  assign grant_if = bus.if_req && (!bus.lsu_req || (streak_q == STREAK_MAX));

  assign tmo_en  = (state_q == BUSY);
  assign tmo_clr = (state_q != BUSY) || bus.mem_ack || tmo_expired;

  riscv_mem_arbiter_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_IF;
      streak_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_req || bus.lsu_req) begin
            state_q <= BUSY;
            if (grant_if) begin
              owner_q  <= OWNER_IF;
              addr_q   <= bus.if_addr;
              we_q     <= 1'b0;
              be_q     <= '1;
              wdata_q  <= '0;
              streak_q <= '0;
            end else begin
              owner_q <= OWNER_LSU;
              addr_q  <= bus.lsu_addr;
              we_q    <= bus.lsu_we;
              be_q    <= bus.lsu_be;
              wdata_q <= bus.lsu_wdata;
              // Streak only grows while a fetch is actually being held off.
              if (!bus.if_req) begin
                streak_q <= '0;
              end else if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + 1'b1;
              end
            end
          end
        end
        BUSY: begin
          // An ack on the expiry cycle still counts as a good completion.
          if (bus.mem_ack) begin
            rdata_q <= bus.mem_rdata;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (tmo_expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp_if  = (state_q == RESP) && (owner_q == OWNER_IF);
  assign resp_lsu = (state_q == RESP) && (owner_q == OWNER_LSU);

  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);

  // The non-owner sees zeros rather than the shared response registers.
  assign bus.if_ack    = resp_if;
  assign bus.if_rdata  = resp_if ? rdata_q : '0;
  assign bus.if_err    = resp_if && err_q;
  assign bus.lsu_ack   = resp_lsu;
  assign bus.lsu_rdata = resp_lsu ? rdata_q : '0;
  assign bus.lsu_err   = resp_lsu && err_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: transaction-level reference of the arbitration
// rules, requester/memory models, per-cycle output comparison, and literal
// expectations for the directed scenarios.
module tb_riscv_mem_arbiter;
  import riscv_mem_arbiter_pkg::*;

  localparam int AW           = 32;
  localparam int DW           = 32;
  localparam int BW           = DW / 8;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT_CYC  = 64;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic          who;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            mreq_cycles;
    int            rise_cyc;
    int            req_cyc;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  riscv_mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // requester models
  logic if_pend  = 1'b0;
  logic lsu_pend = 1'b0;
  req_t if_cur, lsu_cur;
  int   if_since  = 0;
  int   lsu_since = 0;
  req_t if_q[$];
  req_t lsu_q[$];
  int   if_mode  = 0;   // 0 off, 1 random, 2 always requesting
  int   lsu_mode = 0;

  // memory model
  int            lat_mode = 0;  // -1 random mix, -2 never ack, >=0 fixed
  logic          stray_on = 1'b0;
  logic [DW-1:0] rd_q[$];

  // reference of the access in flight
  logic          acc_on = 1'b0;
  int            g = 0;
  int            e = -1;
  int            lat = 0;
  logic          owner = OWNER_IF;
  req_t          acc;
  logic [DW-1:0] exp_rd = '0;
  logic          exp_err = 1'b0;
  int            m_streak = 0;

  // observed completions
  obs_t lg[$];
  obs_t cur_obs;
  logic prev_mreq = 1'b0;

  function automatic req_t mk_req(logic [AW-1:0] a, logic w, logic [BW-1:0] b, logic [DW-1:0] d);
    req_t r;
    r.addr = a; r.we = w; r.be = b; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rand_req();
    return mk_req($urandom, 1'($urandom_range(0, 1)), BW'($urandom), $urandom);
  endfunction

  function automatic int pick_lat();
    int r;
    if (lat_mode != -1) return lat_mode;
    r = $urandom_range(0, 99);
    if (r < 3) return -2;
    if (r < 6) return TIMEOUT_CYC - 1;
    return $urandom_range(0, 3);
  endfunction

  function automatic logic in_busy();
    return acc_on && (cyc >= g) && ((e < 0) || (cyc < e));
  endfunction

  function automatic logic in_resp();
    return acc_on && (e >= 0) && (cyc == e);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic b, r, ri, rl;
    b  = in_busy();
    r  = in_resp();
    ri = r && (owner == OWNER_IF);
    rl = r && (owner == OWNER_LSU);
    chk("busy", bus.busy, b || r);
    chk("mem_req", bus.mem_req, b);
    if (b) begin
      chk("mem_addr", bus.mem_addr, acc.addr);
      chk("mem_we", bus.mem_we, acc.we);
      chk("mem_be", bus.mem_be, acc.be);
      if (owner == OWNER_LSU) chk("mem_wdata", bus.mem_wdata, acc.wdata);
    end
    chk("if_ack", bus.if_ack, ri);
    chk("if_rdata", bus.if_rdata, ri ? exp_rd : '0);
    chk("if_err", bus.if_err, ri && exp_err);
    chk("lsu_ack", bus.lsu_ack, rl);
    chk("lsu_rdata", bus.lsu_rdata, rl ? exp_rd : '0);
    chk("lsu_err", bus.lsu_err, rl && exp_err);
    // log what the DUT actually did, for the literal scenario checks
    if (bus.mem_req && !prev_mreq) begin
      cur_obs.addr = bus.mem_addr; cur_obs.we = bus.mem_we;
      cur_obs.be = bus.mem_be; cur_obs.wdata = bus.mem_wdata;
      cur_obs.mreq_cycles = 0; cur_obs.rise_cyc = cyc;
    end
    if (bus.mem_req) cur_obs.mreq_cycles++;
    prev_mreq = bus.mem_req;
    if (bus.if_ack || bus.lsu_ack) begin
      cur_obs.who   = bus.lsu_ack;
      cur_obs.rdata = bus.lsu_ack ? bus.lsu_rdata : bus.if_rdata;
      cur_obs.err   = bus.lsu_ack ? bus.lsu_err : bus.if_err;
      cur_obs.req_cyc = bus.lsu_ack ? lsu_since : if_since;
      lg.push_back(cur_obs);
    end
  endtask

  // Called at a falling edge: decides inputs for the next rising edge and
  // advances the reference.
  task automatic plan_next();
    logic r, bsy, ack, if_wins;
    logic [DW-1:0] rd;
    r   = in_resp();
    bsy = in_busy();
    if (r && owner == OWNER_IF)  if_pend  = 1'b0;
    if (r && owner == OWNER_LSU) lsu_pend = 1'b0;
    if (!if_pend) begin
      if (if_q.size() > 0) begin
        if_cur = if_q.pop_front(); if_pend = 1'b1; if_since = cyc;
      end else if (if_mode == 2 || (if_mode == 1 && $urandom_range(0, 3) == 0)) begin
        if_cur = rand_req(); if_pend = 1'b1; if_since = cyc;
      end else begin
        if_cur.addr = $urandom;
      end
    end
    if (!lsu_pend) begin
      if (lsu_q.size() > 0) begin
        lsu_cur = lsu_q.pop_front(); lsu_pend = 1'b1; lsu_since = cyc;
      end else if (lsu_mode == 2 || (lsu_mode == 1 && $urandom_range(0, 3) == 0)) begin
        lsu_cur = rand_req(); lsu_pend = 1'b1; lsu_since = cyc;
      end else begin
        lsu_cur = rand_req();
      end
    end
    bus.if_req    = if_pend;
    bus.if_addr   = if_cur.addr;
    bus.lsu_req   = lsu_pend;
    bus.lsu_we    = lsu_cur.we;
    bus.lsu_be    = lsu_cur.be;
    bus.lsu_addr  = lsu_cur.addr;
    bus.lsu_wdata = lsu_cur.wdata;

    ack = 1'b0;
    rd  = $urandom;
    if (bsy) begin
      if (lat >= 0 && cyc == g + lat) begin
        ack = 1'b1;
        if (rd_q.size() > 0) rd = rd_q.pop_front();
        exp_rd = rd; exp_err = 1'b0; e = cyc + 1;
      end else if (cyc == g + TIMEOUT_CYC - 1) begin
        exp_rd = '0; exp_err = 1'b1; e = cyc + 1;
      end
    end else if (stray_on) begin
      ack = ($urandom_range(0, 2) == 0);
    end
    bus.mem_ack   = ack;
    bus.mem_rdata = rd;

    // a new access can start one cycle after the response cycle
    if (rst_n && (if_pend || lsu_pend) && (!acc_on || (e >= 0 && cyc + 1 >= e + 2))) begin
      if_wins = if_pend && (!lsu_pend || m_streak == STARVE_LIMIT);
      acc_on = 1'b1; g = cyc + 1; e = -1;
      owner = if_wins ? OWNER_IF : OWNER_LSU;
      if (if_wins) begin
        acc = mk_req(if_cur.addr, 1'b0, '1, '0);
        m_streak = 0;
      end else begin
        acc = lsu_cur;
        m_streak = !if_pend ? 0 : (m_streak < STARVE_LIMIT ? m_streak + 1 : m_streak);
      end
      lat = pick_lat();
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
    plan_next();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((if_pend || lsu_pend || if_q.size() > 0 || lsu_q.size() > 0 ||
            (acc_on && !(e >= 0 && cyc > e))) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: traffic still outstanding after %0d cycles", budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic exp_who [6];
    exp_who[0] = OWNER_LSU; exp_who[1] = OWNER_LSU; exp_who[2] = OWNER_LSU;
    exp_who[3] = OWNER_LSU; exp_who[4] = OWNER_IF;  exp_who[5] = OWNER_LSU;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_be = '0; bus.lsu_addr = '0; bus.lsu_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    if_cur = mk_req('0, 1'b0, '0, '0);
    lsu_cur = mk_req('0, 1'b0, '0, '0);
    acc = mk_req('0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_if_ack", bus.if_ack, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_lsu_ack", bus.lsu_ack, 0);
    chk("rst_lsu_err", bus.lsu_err, 0);

    // lone fetch, ack after two memory cycles
    if_q.push_back(mk_req(32'h100, 1'b0, '1, '0));
    rd_q.push_back(32'hDEADBEEF);
    lat_mode = 1;
    k = lg.size();
    rst_n = 1'b1;
    plan_next();
    run_idle(50);
    chk("t1_count", lg.size(), k + 1);
    if (lg.size() > k) begin
      chk("t1_who", lg[k].who, OWNER_IF);
      chk("t1_addr", lg[k].addr, 32'h100);
      chk("t1_we", lg[k].we, 0);
      chk("t1_be", lg[k].be, 4'hF);
      chk("t1_rdata", lg[k].rdata, 32'hDEADBEEF);
      chk("t1_err", lg[k].err, 0);
      chk("t1_latency", lg[k].rise_cyc - lg[k].req_cyc, 1);
      chk("t1_mreq_cycles", lg[k].mreq_cycles, 2);
    end

    // simultaneous requests: store goes first
    lat_mode = 0;
    k = lg.size();
    if_q.push_back(mk_req(32'h300, 1'b0, '1, '0));
    lsu_q.push_back(mk_req(32'h2000, 1'b1, 4'h3, 32'h55AA));
    run_idle(50);
    chk("t2_count", lg.size(), k + 2);
    if (lg.size() > k + 1) begin
      chk("t2_first_who", lg[k].who, OWNER_LSU);
      chk("t2_first_we", lg[k].we, 1);
      chk("t2_first_wdata", lg[k].wdata, 32'h55AA);
      chk("t2_first_be", lg[k].be, 4'h3);
      chk("t2_first_addr", lg[k].addr, 32'h2000);
      chk("t2_second_who", lg[k + 1].who, OWNER_IF);
      chk("t2_second_addr", lg[k + 1].addr, 32'h300);
    end

    // starvation guard
    k = lg.size();
    lsu_mode = 2;
    if_q.push_back(mk_req(32'h400, 1'b0, '1, '0));
    for (int n = 0; n < 300 && lg.size() < k + 6; n++) step();
    lsu_mode = 0;
    run_idle(100);
    chk("t3_count_ok", lg.size() >= k + 6, 1);
    if (lg.size() >= k + 6) begin
      for (int i = 0; i < 6; i++) chk("t3_grant_order", lg[k + i].who, exp_who[i]);
      chk("t3_if_addr", lg[k + 4].addr, 32'h400);
    end

    // memory never answers; stray acks afterwards are ignored
    lat_mode = -2;
    stray_on = 1'b1;
    k = lg.size();
    lsu_q.push_back(mk_req(32'h3000, 1'b0, 4'hF, '0));
    run_idle(200);
    repeat (20) step();
    chk("t4_count", lg.size(), k + 1);
    if (lg.size() > k) begin
      chk("t4_who", lg[k].who, OWNER_LSU);
      chk("t4_err", lg[k].err, 1);
      chk("t4_rdata", lg[k].rdata, 0);
      chk("t4_mreq_cycles", lg[k].mreq_cycles, 64);
    end

    // ack on the expiry cycle wins
    stray_on = 1'b0;
    lat_mode = TIMEOUT_CYC - 1;
    rd_q.push_back(32'h12345678);
    k = lg.size();
    if_q.push_back(mk_req(32'h500, 1'b0, '1, '0));
    run_idle(200);
    chk("t5_count", lg.size(), k + 1);
    if (lg.size() > k) begin
      chk("t5_err", lg[k].err, 0);
      chk("t5_rdata", lg[k].rdata, 32'h12345678);
      chk("t5_mreq_cycles", lg[k].mreq_cycles, 64);
    end

    // asynchronous reset in the middle of an access
    lat_mode = -2;
    k = lg.size();
    if_q.push_back(mk_req(32'h600, 1'b0, '1, '0));
    repeat (4) step();
    chk("t6_pre_mem_req", bus.mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_mem_req", bus.mem_req, 0);
    chk("t6_async_busy", bus.busy, 0);
    chk("t6_async_if_ack", bus.if_ack, 0);
    chk("t6_async_lsu_ack", bus.lsu_ack, 0);
    acc_on = 1'b0; if_pend = 1'b0; lsu_pend = 1'b0; m_streak = 0;
    bus.if_req = 1'b0; bus.lsu_req = 1'b0; bus.mem_ack = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    lat_mode = 0;
    rd_q.push_back(32'hA5A50F0F);
    if_q.push_back(mk_req(32'h700, 1'b0, '1, '0));
    run_idle(50);
    chk("t6_count", lg.size(), k + 1);
    if (lg.size() > k) begin
      chk("t6_who", lg[k].who, OWNER_IF);
      chk("t6_addr", lg[k].addr, 32'h700);
      chk("t6_rdata", lg[k].rdata, 32'hA5A50F0F);
      chk("t6_err", lg[k].err, 0);
    end

    // random traffic against the reference
    if_mode = 1; lsu_mode = 1; lat_mode = -1; stray_on = 1'b1;
    repeat (3000) step();
    if_mode = 0; lsu_mode = 0;
    run_idle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
